// File: rtl/mips_register_file_if.sv
// ============================================================================
// Module  : mips_register_file_if
// Purpose : Read/write/latch bus between the multi-cycle control path and the
//           MIPS general-purpose register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  LoadAB;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, LoadAB,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, LoadAB,
    output ReadData1, ReadData2
  );
endinterface

`default_nettype wire

// File: rtl/mips_register_file.sv
// ============================================================================
// Module  : mips_register_file
// Purpose : 32-entry register file, $0 hardwired to zero, with registered A/B
//           operand latches and same-edge write-to-latch forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire                   clk,
  input  wire                   reset,
  mips_register_file_if.slave   bus
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;

  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Writes to $0 are dropped here, which also keeps them out of forwarding.
  assign w_wr_en = bus.RegWrite && (bus.WriteReg != '0);

  always_comb begin
    w_rd1 = r_regs[bus.ReadReg1];
    if (bus.ReadReg1 == '0)
      w_rd1 = '0;
    else if (w_wr_en && (bus.WriteReg == bus.ReadReg1))
      w_rd1 = bus.WriteData;
  end

  always_comb begin
    w_rd2 = r_regs[bus.ReadReg2];
    if (bus.ReadReg2 == '0)
      w_rd2 = '0;
    else if (w_wr_en && (bus.WriteReg == bus.ReadReg2))
      w_rd2 = bus.WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (bus.LoadAB) begin
      r_a <= w_rd1;
      r_b <= w_rd2;
    end
  end

  assign bus.ReadData1 = r_a;
  assign bus.ReadData2 = r_b;

endmodule

`default_nettype wire

// File: tb/tb_mips_register_file.sv
// ============================================================================
// Module  : tb_mips_register_file
// Purpose : Directed self-checking bench for mips_register_file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_register_file;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ld, input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite  = we;
    bus.WriteReg  = wa;
    bus.WriteData = wd;
    bus.LoadAB    = ld;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    cyc();
    chk("reset_rd1", bus.ReadData1, 32'h0);
    chk("reset_rd2", bus.ReadData2, 32'h0);

    // Preload $5 and prove it took, then reset must clear it.
    reset = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
    cyc();
    chk("preload_r5", bus.ReadData1, 32'h1234);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    cyc();
    chk("reset_clr_rd1", bus.ReadData1, 32'h0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
    cyc();
    chk("after_reset_r5", bus.ReadData1, 32'h0);

    // Write then read back
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd9, 32'h00000007, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd9);
    cyc();
    chk("wr_rd_r8", bus.ReadData1, 32'hDEADBEEF);
    chk("wr_rd_r9", bus.ReadData2, 32'h00000007);

    // $0 hardwired, including no forwarding of a $0 write
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    cyc();
    chk("r0_fwd_rd1", bus.ReadData1, 32'h0);
    chk("r0_fwd_rd2", bus.ReadData2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd8);
    cyc();
    chk("r0_later", bus.ReadData1, 32'h0);
    chk("r0_later_r8", bus.ReadData2, 32'hDEADBEEF);

    // Forwarding on same-edge write + latch
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd3);
    cyc();
    chk("fwd_rd1", bus.ReadData1, 32'h22);
    chk("fwd_rd2", bus.ReadData2, 32'h22);
    drive(1'b1, 5'd2, 32'h99, 1'b1, 5'd3, 5'd2);
    cyc();
    chk("fwd_stored_r3", bus.ReadData1, 32'h22);
    chk("fwd_other_r2", bus.ReadData2, 32'h99);

    // Hold across non-load cycles while inputs change
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd9);
    cyc();
    chk("hold_cap", bus.ReadData1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd8, 32'h0, 1'b0, 5'd9, 5'd3);
      cyc();
      chk($sformatf("hold_rd1_%0d", i), bus.ReadData1, 32'hDEADBEEF);
      chk($sformatf("hold_rd2_%0d", i), bus.ReadData2, 32'h00000007);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd9);
    cyc();
    chk("hold_r8_now0", bus.ReadData1, 32'h0);

    // Top address boundary
    drive(1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd30);
    cyc();
    chk("r31_rd1", bus.ReadData1, 32'hCAFEF00D);
    chk("r30_rd2", bus.ReadData2, 32'h0);

    // Reset beats simultaneous write and latch
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 5'd9);
    cyc();
    chk("rstpri_rd1", bus.ReadData1, 32'h0);
    chk("rstpri_rd2", bus.ReadData2, 32'h0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd31);
    cyc();
    chk("rstpri_r4", bus.ReadData1, 32'h0);
    chk("rstpri_r31", bus.ReadData2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
